// File: rtl/pipe_pkg.sv
// Shared EX->WB pipeline types: default widths, payload layout and occupancy encoding.
package pipe_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  typedef struct packed {
    logic                      regwrite;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0]     result;
  } ex_wb_payload_t;

  // The skid entry can only be valid while the main entry is, so skid alone implies two.
  function automatic logic [1:0] occ_of(input logic main_vld, input logic skid_vld);
    logic [1:0] occ;
    occ = OCC_EMPTY;
    if (skid_vld) begin
      occ = OCC_TWO;
    end else if (main_vld) begin
      occ = OCC_ONE;
    end
    return occ;
  endfunction

endpackage

// File: rtl/wb_fwd_cmp.sv
// WB-stage forwarding comparator: combinational hit when the valid WB entry writes the source register.
// Register 0 never hits, because it is hard-wired and cannot be a forwarding source.
module wb_fwd_cmp
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  i_vld,
  input  logic                  i_regwrite,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [REG_ADDR_W-1:0] i_src,
  output logic                  o_hit
);

  logic w_rd_match;
  logic w_rd_nonzero;

  assign w_rd_match   = (i_rd == i_src);
  assign w_rd_nonzero = (i_rd != '0);
  assign o_hit        = i_vld && i_regwrite && w_rd_match && w_rd_nonzero;

endmodule

// File: rtl/ex_wb_pipe_reg.sv
// EX->WB register with a 2-entry skid buffer, 1-cycle latency, sync flush and $zero write suppression.
// in_ready is !skid_valid straight from a flop, so WB back-pressure never drops or duplicates; EX_WB_FWD_EN adds forwarding.
module ex_wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W            = DEF_DATA_W,
  parameter int REG_ADDR_W        = DEF_REG_ADDR_W,
  parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_regwrite,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_regwrite,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]     out_result,
  output logic [1:0]            occupancy
`ifdef EX_WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0] fwd_rs,
  input  logic [REG_ADDR_W-1:0] fwd_rt,
  output logic                  fwd_rs_hit,
  output logic                  fwd_rt_hit,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  typedef struct packed {
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     result;
  } entry_t;

  logic   r_main_vld;
  logic   r_skid_vld;
  entry_t r_main;
  entry_t r_skid;

  logic   w_acc;
  logic   w_ret;
  logic   w_rd_zero;
  entry_t w_cap;
  logic   w_main_vld_nxt;
  logic   w_skid_vld_nxt;
  entry_t w_main_nxt;
  entry_t w_skid_nxt;

  assign in_ready = !r_skid_vld;
  assign w_acc    = in_valid && in_ready;
  assign w_ret    = r_main_vld && out_ready;

  // Suppression happens on capture so both entries already hold the final regwrite.
  assign w_rd_zero       = (in_rd == '0);
  assign w_cap.regwrite  = in_regwrite && !(ZERO_REG_SUPPRESS && w_rd_zero);
  assign w_cap.rd        = in_rd;
  assign w_cap.result    = in_result;

  always_comb begin
    w_main_vld_nxt = r_main_vld;
    w_skid_vld_nxt = r_skid_vld;
    w_main_nxt     = r_main;
    w_skid_nxt     = r_skid;
    if (flush) begin
      // Payloads are left stale; only the valid bits matter once flushed.
      w_main_vld_nxt = 1'b0;
      w_skid_vld_nxt = 1'b0;
    end else if (r_skid_vld) begin
      if (w_ret) begin
        w_main_nxt     = r_skid;
        w_skid_vld_nxt = 1'b0;
        w_skid_nxt     = '0;
      end
    end else if (r_main_vld) begin
      if (w_acc && w_ret) begin
        w_main_nxt = w_cap;
      end else if (w_acc) begin
        w_skid_nxt     = w_cap;
        w_skid_vld_nxt = 1'b1;
      end else if (w_ret) begin
        w_main_vld_nxt = 1'b0;
      end
    end else if (w_acc) begin
      w_main_nxt     = w_cap;
      w_main_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_main_vld <= w_main_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
    end
  end

  assign out_valid    = r_main_vld;
  assign out_regwrite = r_main_vld && r_main.regwrite;
  assign out_rd       = r_main.rd;
  assign out_result   = r_main.result;
  assign occupancy    = occ_of(r_main_vld, r_skid_vld);

`ifdef EX_WB_FWD_EN
  wb_fwd_cmp #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs (
    .i_vld      (out_valid),
    .i_regwrite (out_regwrite),
    .i_rd       (out_rd),
    .i_src      (fwd_rs),
    .o_hit      (fwd_rs_hit)
  );

  wb_fwd_cmp #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rt (
    .i_vld      (out_valid),
    .i_regwrite (out_regwrite),
    .i_rd       (out_rd),
    .i_src      (fwd_rt),
    .o_hit      (fwd_rt_hit)
  );

  assign fwd_data = out_result;
`endif

endmodule

// File: tb/tb_ex_wb_pipe_reg.sv
// Bench for ex_wb_pipe_reg: directed vectors push expected WB entries into a queue; a monitor pops them on each retire.
module tb_ex_wb_pipe_reg;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_regwrite;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_result;
  logic          out_valid;
  logic          out_ready;
  logic          out_regwrite;
  logic [AW-1:0] out_rd;
  logic [DW-1:0] out_result;
  logic [1:0]    occupancy;
`ifdef EX_WB_FWD_EN
  logic [AW-1:0] fwd_rs;
  logic [AW-1:0] fwd_rt;
  logic          fwd_rs_hit;
  logic          fwd_rt_hit;
  logic [DW-1:0] fwd_data;
`endif

  int n_vec = 0;
  int n_err = 0;
  ex_wb_payload_t exp_q[$];

  always #5 Clk = ~Clk;

  ex_wb_pipe_reg #(
    .DATA_W            (DW),
    .REG_ADDR_W        (AW),
    .ZERO_REG_SUPPRESS (1'b1)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_regwrite  (in_regwrite),
    .in_rd        (in_rd),
    .in_result    (in_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_regwrite (out_regwrite),
    .out_rd       (out_rd),
    .out_result   (out_result),
    .occupancy    (occupancy)
`ifdef EX_WB_FWD_EN
    ,
    .fwd_rs       (fwd_rs),
    .fwd_rt       (fwd_rt),
    .fwd_rs_hit   (fwd_rs_hit),
    .fwd_rt_hit   (fwd_rt_hit),
    .fwd_data     (fwd_data)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Hold the vector until in_ready, record the expected WB entry, then let one edge accept it.
  task automatic send(input logic rw, input logic [AW-1:0] rd, input logic [DW-1:0] res, input logic exp_rw);
    in_valid    = 1'b1;
    in_regwrite = rw;
    in_rd       = rd;
    in_result   = res;
    for (int k = 0; k < 20 && !in_ready; k++) step();
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready=0, expected 1 within 20 cycles");
    end else begin
      exp_q.push_back('{regwrite: exp_rw, rd: rd, result: res});
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_regwrite"}, out_regwrite, 0);
    chk({tag, "_out_rd"}, out_rd, 0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_occupancy"}, occupancy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  // Monitor: every retire seen on the falling edge must match the oldest expected entry.
  initial begin
    ex_wb_payload_t e;
    forever begin
      @(negedge Clk);
      if (Reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL mon_unexpected: got rd=%0d result=%0h, expected no entry", out_rd, out_result);
        end else begin
          e = exp_q.pop_front();
          chk("mon_regwrite", out_regwrite, e.regwrite);
          chk("mon_rd", out_rd, e.rd);
          chk("mon_result", out_result, e.result);
        end
      end
    end
  end

  initial begin
    Reset       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_regwrite = 1'b0;
    in_rd       = '0;
    in_result   = '0;
    out_ready   = 1'b0;
`ifdef EX_WB_FWD_EN
    fwd_rs      = '0;
    fwd_rt      = '0;
`endif

    @(negedge Clk);
    chk_reset_state("init");
    step();
    Reset = 1'b1;

    // Streaming: each result visible one edge after acceptance, occupancy pinned at one.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(1'b1, AW'(i), DW'(i), 1'b1);
      chk("stream_valid", out_valid, 1);
      chk("stream_result", out_result, i);
      chk("stream_occ", occupancy, 1);
      chk("stream_in_ready", in_ready, 1);
    end
    step();
    chk("stream_drain_occ", occupancy, 0);

    // Back-pressure: A and B fill both entries, C waits; outputs frozen until WB is ready.
    out_ready = 1'b0;
    send(1'b1, 5'd1, 32'h11, 1'b1);
    send(1'b1, 5'd2, 32'h22, 1'b1);
    chk("bp_occ", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    in_valid    = 1'b1;
    in_regwrite = 1'b1;
    in_rd       = 5'd3;
    in_result   = 32'h33;
    step();
    chk("bp_hold_occ", occupancy, 2);
    chk("bp_hold_result", out_result, 32'h11);
    chk("bp_hold_rd", out_rd, 1);
    out_ready = 1'b1;
    send(1'b1, 5'd3, 32'h33, 1'b1);
    step();
    step();
    chk("bp_drain_occ", occupancy, 0);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Flush with both entries held and a pending input: everything disappears.
    out_ready = 1'b0;
    send(1'b1, 5'd4, 32'h44, 1'b1);
    send(1'b1, 5'd5, 32'h55, 1'b1);
    chk("fl_pre_occ", occupancy, 2);
    in_valid    = 1'b1;
    in_regwrite = 1'b1;
    in_rd       = 5'd6;
    in_result   = 32'h66;
    flush       = 1'b1;
    exp_q.delete();
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_out_regwrite", out_regwrite, 0);
    chk("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("fl_input_dropped", out_valid, 0);

    // Flush on an empty register drops an accept in the same cycle.
    in_valid    = 1'b1;
    in_regwrite = 1'b1;
    in_rd       = 5'd8;
    in_result   = 32'h88;
    flush       = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_acc_dropped", out_valid, 0);
    chk("fl_acc_occ", occupancy, 0);

    // $zero destination: accepted and retired, but never writes.
    send(1'b1, 5'd0, 32'h5, 1'b0);
    chk("zr_valid", out_valid, 1);
    chk("zr_regwrite", out_regwrite, 0);
    send(1'b1, 5'd7, 32'h5, 1'b1);
    chk("zr7_regwrite", out_regwrite, 1);
    chk("zr7_rd", out_rd, 7);
    step();
    chk("zr_drain_occ", occupancy, 0);

`ifdef EX_WB_FWD_EN
    out_ready = 1'b0;
    send(1'b1, 5'd9, 32'hCAFE, 1'b1);
    fwd_rs = 5'd9;
    fwd_rt = 5'd0;
    #1;
    chk("fwd_rs_hit", fwd_rs_hit, 1);
    chk("fwd_rt_hit", fwd_rt_hit, 0);
    chk("fwd_data", fwd_data, 32'hCAFE);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send(1'b1, 5'd0, 32'hCAFE, 1'b0);
    fwd_rs = 5'd0;
    fwd_rt = 5'd0;
    #1;
    chk("fwd_rd0_rs_hit", fwd_rs_hit, 0);
    chk("fwd_rd0_rt_hit", fwd_rt_hit, 0);
    out_ready = 1'b1;
    step();
`endif

    // Reset asserted with both entries full, then a fresh transfer after release.
    out_ready = 1'b0;
    send(1'b1, 5'd1, 32'hA1, 1'b1);
    send(1'b1, 5'd2, 32'hA2, 1'b1);
    chk("rst_pre_occ", occupancy, 2);
    Reset = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_state("midrst");
    step();
    Reset     = 1'b1;
    out_ready = 1'b1;
    send(1'b1, 5'd3, 32'hDEADBEEF, 1'b1);
    chk("rst_out_valid", out_valid, 1);
    chk("rst_out_rd", out_rd, 3);
    chk("rst_out_result", out_result, 32'hDEADBEEF);
    step();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    chk("end_queue_empty", exp_q.size(), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
